// File: rtl/wb_ctrl.sv
// Write-back controller: arbitrates execute/load results into one registered regsfile write
// and tracks in-flight loads for decode hazards. Optional macro WB_RR_ARB_EN selects round-robin arbitration.
module wb_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [ADDR_W-1:0] ld_waddr_i,
  input  logic [DATA_W-1:0] ld_rdata_i,
  input  logic [2:0]        ld_funct3_i,
  input  logic [1:0]        ld_off_i,
  input  logic              ld_issue_i,
  input  logic [ADDR_W-1:0] ld_issue_addr_i,
  input  logic [ADDR_W-1:0] chk_addr1_i,
  input  logic [ADDR_W-1:0] chk_addr2_i,
  output logic              hazard_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
);

  function automatic logic [DATA_W-1:0] fmt_load(
    input logic [DATA_W-1:0] rdata,
    input logic [2:0]        funct3,
    input logic [1:0]        off
  );
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [DATA_W-1:0] res_s;
    case (off)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    half_s = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'b000:  res_s = {{(DATA_W-8){byte_s[7]}}, byte_s};
      3'b001:  res_s = {{(DATA_W-16){half_s[15]}}, half_s};
      3'b100:  res_s = {{(DATA_W-8){1'b0}}, byte_s};
      3'b101:  res_s = {{(DATA_W-16){1'b0}}, half_s};
      default: res_s = rdata;
    endcase
    return res_s;
  endfunction

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              ld_xfer_s, ex_xfer_s;

`ifdef WB_RR_ARB_EN
  logic last_ld_q, last_ld_d;

  // Under contention the source not granted most recently wins
  assign ld_ready_o = rst & ~(ex_valid_i & ld_valid_i & last_ld_q);
  assign ex_ready_o = rst & (~ld_valid_i | (ex_valid_i & last_ld_q));
`else
  assign ld_ready_o = rst;
  assign ex_ready_o = rst & ~ld_valid_i;
`endif

  assign ld_xfer_s = ld_valid_i & ld_ready_o;
  assign ex_xfer_s = ex_valid_i & ex_ready_o;

  // Write-port next state; address/data hold when nothing transfers
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (ld_xfer_s) begin
      we_d    = |ld_waddr_i;
      waddr_d = ld_waddr_i;
      wdata_d = fmt_load(ld_rdata_i, ld_funct3_i, ld_off_i);
    end else if (ex_xfer_s) begin
      we_d    = |ex_waddr_i;
      waddr_d = ex_waddr_i;
      wdata_d = ex_wdata_i;
    end else begin
      we_d    = 1'b0;
    end
  end

  // Scoreboard next state: clear on load write-back, then set on issue so set wins
  always_comb begin
    busy_d = busy_q;
    if (ld_xfer_s) begin
      busy_d[ld_waddr_i] = 1'b0;
    end else begin
      busy_d[ld_waddr_i] = busy_q[ld_waddr_i];
    end
    if (ld_issue_i) begin
      busy_d[ld_issue_addr_i] = 1'b1;
    end else begin
      busy_d[ld_issue_addr_i] = busy_d[ld_issue_addr_i];
    end
    busy_d[0] = 1'b0;
  end

`ifdef WB_RR_ARB_EN
  // Last-grant next state
  always_comb begin
    if (ld_xfer_s) begin
      last_ld_d = 1'b1;
    end else if (ex_xfer_s) begin
      last_ld_d = 1'b0;
    end else begin
      last_ld_d = last_ld_q;
    end
  end

  // Last-grant register; reset to "ld" so ex wins the first contention
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ld_q <= 1'b1;
    end else begin
      last_ld_q <= last_ld_d;
    end
  end
`endif

  // Output stage and scoreboard registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      busy_q  <= {NREG{1'b0}};
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

  assign hazard_o = ((chk_addr1_i != {ADDR_W{1'b0}}) & busy_q[chk_addr1_i]) |
                    ((chk_addr2_i != {ADDR_W{1'b0}}) & busy_q[chk_addr2_i]);

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed scenarios plus randomized traffic against a
// behavioural model (arbitration rules, load formatting by shifts, scoreboard as a bit array).
module tb_wb_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid_i, ex_ready_o;
  logic [ADDR_W-1:0] ex_waddr_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              ld_valid_i, ld_ready_o;
  logic [ADDR_W-1:0] ld_waddr_i;
  logic [DATA_W-1:0] ld_rdata_i;
  logic [2:0]        ld_funct3_i;
  logic [1:0]        ld_off_i;
  logic              ld_issue_i;
  logic [ADDR_W-1:0] ld_issue_addr_i;
  logic [ADDR_W-1:0] chk_addr1_i, chk_addr2_i;
  logic              hazard_o, we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] wdata_o;

  always #5 clk = ~clk;

  wb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_waddr_i(ld_waddr_i), .ld_rdata_i(ld_rdata_i),
    .ld_funct3_i(ld_funct3_i), .ld_off_i(ld_off_i),
    .ld_issue_i(ld_issue_i), .ld_issue_addr_i(ld_issue_addr_i),
    .chk_addr1_i(chk_addr1_i), .chk_addr2_i(chk_addr2_i), .hazard_o(hazard_o),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [NREG-1:0]   m_busy;
  logic              m_last_ld;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  logic              exp_we, exp_ex_rdy, exp_ld_rdy, exp_hz;
  logic              obs_ex_rdy, obs_ld_rdy, obs_hz;
  logic              did_ld, did_ex;

  function automatic logic [31:0] ref_fmt(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'h0000_00FF;
    h = (w >> (16 * off[1])) & 32'h0000_FFFF;
    if (f3 == 3'b000) return (b ^ 32'h0000_0080) - 32'h0000_0080;
    if (f3 == 3'b001) return (h ^ 32'h0000_8000) - 32'h0000_8000;
    if (f3 == 3'b100) return b;
    if (f3 == 3'b101) return h;
    return w;
  endfunction

  task automatic idle_inputs();
    ex_valid_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'd0;
    ld_valid_i = 1'b0; ld_waddr_i = 5'd0; ld_rdata_i = 32'd0;
    ld_funct3_i = 3'b010; ld_off_i = 2'd0;
    ld_issue_i = 1'b0; ld_issue_addr_i = 5'd0;
    chk_addr1_i = 5'd0; chk_addr2_i = 5'd0;
  endtask

  task automatic model_reset();
    m_busy = '0; m_last_ld = 1'b1; m_waddr = 5'd0; m_wdata = 32'd0; exp_we = 1'b0;
    did_ld = 1'b0; did_ex = 1'b0;
  endtask

  // One clock: predict and capture combinational outputs, take the edge, update the model.
  task automatic advance();
    logic ex_win, ldx, exx;
    logic [31:0] ld_val;
    #1;
    ex_win = 1'b0;
`ifdef WB_RR_ARB_EN
    if (ex_valid_i && ld_valid_i) ex_win = m_last_ld;
`endif
    exp_ld_rdy = !(ld_valid_i && ex_valid_i && ex_win);
    exp_ex_rdy = !ld_valid_i || ex_win;
    exp_hz = ((chk_addr1_i != 5'd0) && m_busy[chk_addr1_i]) || ((chk_addr2_i != 5'd0) && m_busy[chk_addr2_i]);
    ldx = ld_valid_i && exp_ld_rdy;
    exx = ex_valid_i && exp_ex_rdy;
    ld_val = ref_fmt(ld_rdata_i, ld_funct3_i, ld_off_i);
    obs_ex_rdy = ex_ready_o; obs_ld_rdy = ld_ready_o; obs_hz = hazard_o;
    @(posedge clk);
    #1;
    if (ldx) begin
      exp_we = (ld_waddr_i != 5'd0); m_waddr = ld_waddr_i; m_wdata = ld_val;
      m_busy[ld_waddr_i] = 1'b0; m_last_ld = 1'b1;
    end else if (exx) begin
      exp_we = (ex_waddr_i != 5'd0); m_waddr = ex_waddr_i; m_wdata = ex_wdata_i;
      m_last_ld = 1'b0;
    end else begin
      exp_we = 1'b0;
    end
    if (ld_issue_i) m_busy[ld_issue_addr_i] = 1'b1;
    m_busy[0] = 1'b0;
    did_ld = ldx; did_ex = exx;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    chk_addr1_i = 5'd7; chk_addr2_i = 5'd9;
    #12;
    n_checks++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", we_o); end
    n_checks++; if (waddr_o !== 5'd0) begin n_fail++; $display("FAIL reset_waddr got %0d want 0", waddr_o); end
    n_checks++; if (wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", wdata_o); end
    n_checks++; if ({ex_ready_o, ld_ready_o} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {ex_ready_o, ld_ready_o}); end
    n_checks++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b want 0", hazard_o); end
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
  endtask

  task automatic test_ex_write();
    ex_valid_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h1234_5678;
    advance();
    ex_valid_i = 1'b0;
    n_checks++; if (obs_ex_rdy !== 1'b1) begin n_fail++; $display("FAIL ex_ready got %b want 1", obs_ex_rdy); end
    n_checks++; if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd5, 32'h1234_5678})
      begin n_fail++; $display("FAIL ex_write got we=%b a=%0d d=%h want we=1 a=5 d=12345678", we_o, waddr_o, wdata_o); end
    advance();
    n_checks++; if (we_o !== 1'b0 || waddr_o !== 5'd5) begin n_fail++; $display("FAIL ex_after got we=%b a=%0d want we=0 a=5", we_o, waddr_o); end
  endtask

  task automatic test_load_format();
    logic [2:0] f3s [3] = '{3'b000, 3'b100, 3'b001};
    logic [1:0] offs [3] = '{2'd3, 2'd3, 2'd2};
    logic [31:0] wants [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
    for (int i = 0; i < 3; i++) begin
      ld_valid_i = 1'b1; ld_waddr_i = 5'd2; ld_rdata_i = 32'h80FF_7F81;
      ld_funct3_i = f3s[i]; ld_off_i = offs[i];
      advance();
      n_checks++; if (we_o !== 1'b1 || wdata_o !== wants[i])
        begin n_fail++; $display("FAIL ld_fmt%0d got we=%b d=%h want we=1 d=%h", i, we_o, wdata_o, wants[i]); end
    end
    for (int i = 0; i < 24; i++) begin
      ld_rdata_i = $urandom; ld_funct3_i = 3'($urandom_range(0, 7)); ld_off_i = 2'($urandom_range(0, 3));
      ld_waddr_i = 5'($urandom_range(1, 31));
      advance();
      n_checks++; if (we_o !== 1'b1 || waddr_o !== m_waddr || wdata_o !== m_wdata)
        begin n_fail++; $display("FAIL ld_fmt_rand got we=%b a=%0d d=%h want we=1 a=%0d d=%h", we_o, waddr_o, wdata_o, m_waddr, m_wdata); end
    end
    ld_valid_i = 1'b0;
    advance();
  endtask

  task automatic test_hazard();
    ld_issue_i = 1'b1; ld_issue_addr_i = 5'd7; chk_addr1_i = 5'd7; chk_addr2_i = 5'd0;
    advance();
    n_checks++; if (obs_hz !== 1'b0) begin n_fail++; $display("FAIL hz_before_issue got %b want 0", obs_hz); end
    ld_issue_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      advance();
      n_checks++; if (obs_hz !== 1'b1) begin n_fail++; $display("FAIL hz_pending%0d got %b want 1", i, obs_hz); end
    end
    ld_valid_i = 1'b1; ld_waddr_i = 5'd7; ld_rdata_i = 32'hCAFE_0001; ld_funct3_i = 3'b010;
    advance();
    ld_valid_i = 1'b0;
    n_checks++; if (obs_hz !== 1'b1) begin n_fail++; $display("FAIL hz_xfer_cycle got %b want 1", obs_hz); end
    #1;
    n_checks++; if (hazard_o !== 1'b0 || we_o !== 1'b1) begin n_fail++; $display("FAIL hz_drop got hz=%b we=%b want hz=0 we=1", hazard_o, we_o); end
    ld_issue_i = 1'b1; ld_issue_addr_i = 5'd0; chk_addr1_i = 5'd0;
    advance();
    ld_issue_i = 1'b0;
    advance();
    n_checks++; if (obs_hz !== 1'b0) begin n_fail++; $display("FAIL hz_x0 got %b want 0", obs_hz); end
  endtask

  task automatic test_arb();
    do_reset();
    ld_valid_i = 1'b1; ld_waddr_i = 5'd4; ld_rdata_i = 32'hAAAA_0004; ld_funct3_i = 3'b010;
    ex_valid_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'hBBBB_0003;
    advance();
`ifdef WB_RR_ARB_EN
    n_checks++; if ({obs_ex_rdy, obs_ld_rdy, waddr_o} !== {1'b1, 1'b0, 5'd3})
      begin n_fail++; $display("FAIL arb_first got exr=%b ldr=%b a=%0d want exr=1 ldr=0 a=3", obs_ex_rdy, obs_ld_rdy, waddr_o); end
    ex_valid_i = 1'b0;
    advance();
    ld_valid_i = 1'b0;
    n_checks++; if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd4, 32'hAAAA_0004})
      begin n_fail++; $display("FAIL arb_second got we=%b a=%0d d=%h want we=1 a=4 d=aaaa0004", we_o, waddr_o, wdata_o); end
`else
    n_checks++; if ({obs_ex_rdy, obs_ld_rdy, waddr_o} !== {1'b0, 1'b1, 5'd4})
      begin n_fail++; $display("FAIL arb_first got exr=%b ldr=%b a=%0d want exr=0 ldr=1 a=4", obs_ex_rdy, obs_ld_rdy, waddr_o); end
    ld_valid_i = 1'b0;
    advance();
    ex_valid_i = 1'b0;
    n_checks++; if ({obs_ex_rdy, we_o, waddr_o, wdata_o} !== {1'b1, 1'b1, 5'd3, 32'hBBBB_0003})
      begin n_fail++; $display("FAIL arb_second got exr=%b we=%b a=%0d d=%h want exr=1 we=1 a=3 d=bbbb0003", obs_ex_rdy, we_o, waddr_o, wdata_o); end
`endif
    advance();
  endtask

  task automatic test_set_clear();
    ld_issue_i = 1'b1; ld_issue_addr_i = 5'd9;
    advance();
    ld_valid_i = 1'b1; ld_waddr_i = 5'd9; ld_rdata_i = 32'h0000_0009; ld_funct3_i = 3'b010;
    advance();
    ld_valid_i = 1'b0; ld_issue_i = 1'b0; chk_addr1_i = 5'd9;
    #1;
    n_checks++; if (hazard_o !== 1'b1 || we_o !== 1'b1 || waddr_o !== 5'd9)
      begin n_fail++; $display("FAIL set_wins got hz=%b we=%b a=%0d want hz=1 we=1 a=9", hazard_o, we_o, waddr_o); end
    ld_valid_i = 1'b1;
    advance();
    ld_valid_i = 1'b0;
    advance();
  endtask

  task automatic test_x0_reset();
    ex_valid_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hDEAD_BEEF;
    advance();
    n_checks++; if (obs_ex_rdy !== 1'b1 || we_o !== 1'b0) begin n_fail++; $display("FAIL x0_write got exr=%b we=%b want exr=1 we=0", obs_ex_rdy, we_o); end
    ex_valid_i = 1'b0; ld_issue_i = 1'b1; ld_issue_addr_i = 5'd12;
    advance();
    ld_issue_i = 1'b0; ex_valid_i = 1'b1; ex_waddr_i = 5'd6; ex_wdata_i = 32'h0000_0066; chk_addr1_i = 5'd12;
    advance();
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if ({we_o, waddr_o, wdata_o, hazard_o, ex_ready_o, ld_ready_o} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL rst_async got we=%b a=%0d d=%h hz=%b exr=%b ldr=%b want all 0", we_o, waddr_o, wdata_o, hazard_o, ex_ready_o, ld_ready_o); end
    @(posedge clk); #1;
    rst = 1'b1; ex_valid_i = 1'b0;
    advance();
    n_checks++; if (we_o !== 1'b0 || obs_hz !== 1'b0 || hazard_o !== 1'b0)
      begin n_fail++; $display("FAIL rst_release got we=%b hz=%b/%b want 0", we_o, obs_hz, hazard_o); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!(ex_valid_i && !did_ex)) begin
        ex_valid_i = ($urandom_range(0, 99) < 55); ex_waddr_i = 5'($urandom); ex_wdata_i = $urandom;
      end
      if (!(ld_valid_i && !did_ld)) begin
        ld_valid_i = ($urandom_range(0, 99) < 45); ld_waddr_i = 5'($urandom); ld_rdata_i = $urandom;
        ld_funct3_i = 3'($urandom); ld_off_i = 2'($urandom);
      end
      a = 5'($urandom);
      ld_issue_i = ($urandom_range(0, 99) < 35) && !m_busy[a];
      ld_issue_addr_i = a;
      chk_addr1_i = 5'($urandom); chk_addr2_i = 5'($urandom);
      advance();
      n_checks++; if ({obs_ex_rdy, obs_ld_rdy} !== {exp_ex_rdy, exp_ld_rdy})
        begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b%b want %b%b", cyc, obs_ex_rdy, obs_ld_rdy, exp_ex_rdy, exp_ld_rdy); end
      n_checks++; if (obs_hz !== exp_hz) begin n_fail++; $display("FAIL rnd_hazard cyc %0d got %b want %b", cyc, obs_hz, exp_hz); end
      n_checks++; if ({we_o, waddr_o, wdata_o} !== {exp_we, m_waddr, m_wdata})
        begin n_fail++; $display("FAIL rnd_write cyc %0d got we=%b a=%0d d=%h want we=%b a=%0d d=%h", cyc, we_o, waddr_o, wdata_o, exp_we, m_waddr, m_wdata); end
    end
    idle_inputs();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ex_write();
    test_load_format();
    test_hazard();
    test_arb();
    test_set_clear();
    test_x0_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
